// File: rtl/flow_ctrl.sv
// Pipeline flow control: stall/flush decisions for PC, IF/ID, ID/EX and EX/MEM,
// PC redirect on taken jumps, multi-cycle divide tracking and a stall counter.
module flow_ctrl #(
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic        id_rs1_re_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs2_re_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_rd_we_i,
    input  logic        ex_mem_rd_i,
    input  logic        ex_jump_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        ex_div_start_i,
    input  logic        mem_busy_i,
    output logic        fc_jump_o,
    output logic [31:0] fc_jump_addr_o,
    output logic        fc_bk_pc_o,
    output logic        fc_bk_ifid_o,
    output logic        fc_bk_idex_o,
    output logic        fc_bk_exmem_o,
    output logic        fc_flush_ifid_o,
    output logic        fc_flush_idex_o,
    output logic        fc_flush_exmem_o,
    output logic [31:0] fc_stall_cnt_o
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    typedef enum logic {RUN = 1'b0, DIV = 1'b1} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   div_cnt_reg, div_cnt_next;
    logic [31:0]        stall_cnt_reg;

    logic [1:0]         src_re;
    logic [4:0]         src_addr [2];
    logic [1:0]         src_hit;
    logic               load_use;
    logic               div_active;

    assign src_re      = {id_rs2_re_i, id_rs1_re_i};
    assign src_addr[0] = id_rs1_addr_i;
    assign src_addr[1] = id_rs2_addr_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_re[gi] && (src_addr[gi] == ex_rd_addr_i);
        end
    endgenerate

    // x0 is never a real dependency, so a load targeting it cannot cause a hazard.
    assign load_use   = ex_mem_rd_i && ex_rd_we_i && (ex_rd_addr_i != 5'd0) && (|src_hit);
    assign div_active = (state_reg == DIV) || ex_div_start_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= RUN;
            div_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
        end
    end

    // The divide keeps counting through memory waits; a start seen while memory
    // is busy is dropped and repeats next cycle because EX is held.
    always_comb begin
        state_next   = state_reg;
        div_cnt_next = div_cnt_reg;
        case (state_reg)
            RUN: begin
                if (ex_div_start_i && !mem_busy_i) begin
                    state_next   = DIV;
                    div_cnt_next = CNT_W'(DIV_CYCLES - 1);
                end
            end
            DIV: begin
                div_cnt_next = div_cnt_reg - CNT_W'(1);
                if (div_cnt_reg == CNT_W'(1)) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next   = RUN;
                div_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        fc_jump_o        = 1'b0;
        fc_bk_pc_o       = 1'b0;
        fc_bk_ifid_o     = 1'b0;
        fc_bk_idex_o     = 1'b0;
        fc_bk_exmem_o    = 1'b0;
        fc_flush_ifid_o  = 1'b0;
        fc_flush_idex_o  = 1'b0;
        fc_flush_exmem_o = 1'b0;
        if (mem_busy_i) begin
            fc_bk_pc_o    = 1'b1;
            fc_bk_ifid_o  = 1'b1;
            fc_bk_idex_o  = 1'b1;
            fc_bk_exmem_o = 1'b1;
        end else if (div_active) begin
            fc_bk_pc_o       = 1'b1;
            fc_bk_ifid_o     = 1'b1;
            fc_bk_idex_o     = 1'b1;
            fc_flush_exmem_o = 1'b1;
        end else if (ex_jump_i) begin
            fc_jump_o       = 1'b1;
            fc_flush_ifid_o = 1'b1;
            fc_flush_idex_o = 1'b1;
        end else if (load_use) begin
            fc_bk_pc_o      = 1'b1;
            fc_bk_ifid_o    = 1'b1;
            fc_flush_idex_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (fc_bk_pc_o) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign fc_jump_addr_o = ex_jump_addr_i;
    assign fc_stall_cnt_o = stall_cnt_reg;

endmodule

// File: doc/flow_ctrl.md
# flow_ctrl

Pipeline flow-control unit for the five-stage core. Each cycle it decides stall (`bk`) and flush controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers, plus the PC redirect. Inputs are ID-stage register reads, EX-stage load/branch/divide status and the data-memory busy line. It resolves load-use hazards, taken jumps, multi-cycle divides and memory wait states, and keeps a stall-cycle counter for performance monitoring.

## Interface
- `DIV_CYCLES`, default 4: total cycles a divide occupies EX, including its start cycle; legal range 2..255.
- `clk` in 1: core clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_rs1_addr_i` in 5: ID-stage rs1 index.
- `id_rs1_re_i` in 1: ID-stage reads rs1.
- `id_rs2_addr_i` in 5: ID-stage rs2 index.
- `id_rs2_re_i` in 1: ID-stage reads rs2.
- `ex_rd_addr_i` in 5: EX-stage destination index.
- `ex_rd_we_i` in 1: EX-stage instruction writes rd.
- `ex_mem_rd_i` in 1: EX-stage instruction is a load.
- `ex_jump_i` in 1: EX resolved a taken branch or jump.
- `ex_jump_addr_i` in 32: redirect target.
- `ex_div_start_i` in 1: EX holds a divide that has not yet started.
- `mem_busy_i` in 1: data memory not ready; MEM cannot complete.
- `fc_jump_o` out 1: PC takes `fc_jump_addr_o` at the next edge.
- `fc_jump_addr_o` out 32: redirect target.
- `fc_bk_pc_o`, `fc_bk_ifid_o`, `fc_bk_idex_o`, `fc_bk_exmem_o` out 1 each: hold the named register.
- `fc_flush_ifid_o`, `fc_flush_idex_o`, `fc_flush_exmem_o` out 1 each: load a bubble into the named register.
- `fc_stall_cnt_o` out 32: count of cycles with `fc_bk_pc_o`=1.

## Operation
- State: FSM {RUN, DIV}, a down-counter `div_cnt` (width clog2(DIV_CYCLES)), and `fc_stall_cnt_o`.
- Reset values: RUN, `div_cnt`=0, `fc_stall_cnt_o`=0. In RUN with all inputs 0, every output is 0.
- Control outputs are combinational from state and inputs. Exactly one priority case applies per cycle; every output not listed for that case is 0.
  1. **Memory wait** (`mem_busy_i`=1): all four `bk` outputs=1; no flush; `fc_jump_o`=0.
  2. **Divide** (state DIV, or RUN with `ex_div_start_i`=1): `fc_bk_pc_o`, `fc_bk_ifid_o`, `fc_bk_idex_o`=1 and `fc_flush_exmem_o`=1. `ex_jump_i` is ignored.
  3. **Jump** (`ex_jump_i`=1): `fc_jump_o`=1, `fc_flush_ifid_o`=1, `fc_flush_idex_o`=1.
  4. **Load-use**: fires when `ex_mem_rd_i` & `ex_rd_we_i` & `ex_rd_addr_i`≠0, and either (`id_rs1_re_i` & rs1==rd) or (`id_rs2_re_i` & rs2==rd). Drives `fc_bk_pc_o`=1, `fc_bk_ifid_o`=1, `fc_flush_idex_o`=1.
- `fc_jump_addr_o` = `ex_jump_addr_i` at all times; it is meaningful only when `fc_jump_o`=1.
- The `bk` outputs take priority over flush in the downstream registers. This unit never asserts `bk` and flush on the same register in the same cycle.
- FSM transitions:
  - RUN→DIV on an edge with `ex_div_start_i`=1 and `mem_busy_i`=0; `div_cnt` loads DIV_CYCLES−1.
  - A start that coincides with `mem_busy_i`=1 is not accepted. EX is held, so the start repeats in the next cycle.
  - In DIV, `div_cnt` decrements every edge, including during `mem_busy_i`.
  - DIV→RUN on the edge where `div_cnt`==1.
  - `ex_div_start_i` in DIV is ignored.
- Stall counter: `fc_stall_cnt_o` increments on each edge where `fc_bk_pc_o`=1; it wraps from 0xFFFFFFFF to 0.
- Reset asserted mid-divide returns the FSM to RUN and clears the counters immediately, asynchronously.

## Timing
- Zero-cycle latency on all control outputs (same-cycle combinational decision).
- Jump in cycle N: PC holds the target after edge N; IF/ID and ID/EX hold bubbles in cycle N+1.
- Load-use in cycle N: exactly one bubble. In cycle N+1 the load has reached MEM, so the condition clears unless a new hazard exists.
- Divide accepted in cycle N: stall asserted in cycles N through N+DIV_CYCLES−1; cycle N+DIV_CYCLES is free (with DIV_CYCLES=4: N..N+3).
- Memory wait overlapping a divide: the stall extends to the later of the two releases.

## Test plan
- Load-use on rs2:
  - Stimulus: `ex_mem_rd_i`=1, `ex_rd_we_i`=1, rd=5, `id_rs2_re_i`=1, rs2=5.
  - Response: one cycle of `bk_pc`/`bk_ifid`/`flush_idex`=1; `fc_stall_cnt_o` 0→1.
  - Repeat with rd=0: response is no stall.
- Jump plus load-use in the same cycle:
  - Stimulus: `ex_jump_i`=1, addr 0x0000_0100, with a load-use hazard also present.
  - Response: `fc_jump_o`=1, `fc_jump_addr_o`=0x100, `flush_ifid`/`flush_idex`=1, all `bk`=0.
- Divide with DIV_CYCLES=4:
  - Stimulus: one-cycle `ex_div_start_i` pulse at cycle 10.
  - Response: stalls and `flush_exmem` in cycles 10–13, clear at 14; `fc_stall_cnt_o`=4.
  - A second start pulse at cycle 12 has no effect.
- Memory wait during a divide:
  - Stimulus: `mem_busy_i`=1 in cycles 11–16 with the divide accepted at 10.
  - Response: all four `bk`=1 in cycles 11–16, `flush_exmem`=0 in those cycles; release at 17.
- Reset mid-divide:
  - Stimulus: drop `rst_n` in cycle 12.
  - Response: all outputs 0 immediately, without waiting for a clock edge, and `fc_stall_cnt_o`=0.
  - After release, a new start gives the full 4-cycle stall.
- Counter wrap:
  - Stimulus: force `fc_stall_cnt_o`=0xFFFFFFFF, then apply one stall cycle.
  - Response: `fc_stall_cnt_o` reads 0.
